// File: rtl/div_iter_pkg.sv
// div_iter_pkg: shared state type and iteration constants for the iterative divider.
package div_iter_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} div_state_t;
  localparam int DIV_CNT_W  = 7;
  localparam int DIV_ITER_D = 64;
  localparam int DIV_ITER_W = 32;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring shift-compare-subtract iteration.
module div_step #(
  parameter int W = 64
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic [W-1:0] quo_next
);
  logic [W:0] t;
  logic       ge;
  always_comb begin
    t        = {rem, quo[W-1]};
    ge       = t >= {1'b0, divisor};
    rem_next = ge ? W'(t - {1'b0, divisor}) : t[W-1:0];
    quo_next = {quo[W-2:0], ge};
  end
endmodule

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for RV64M DIV/REM and W variants.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int WLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_signed,
  input  logic            get_div,
  input  logic            is_word,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] c
);
  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [XLEN-1:0]      rem, quo, dvs, rem_n, quo_n;
  logic                 neg_q, neg_r, div_q, word_q;
  logic [XLEN-1:0]      ax, bx, ma, mb, a_wx, q, r, sel, res;
  logic                 sa, sb, bz;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    a_wx = {{(XLEN-WLEN){a[WLEN-1]}}, a[WLEN-1:0]};
    ax   = is_word ? (is_signed ? a_wx : {{(XLEN-WLEN){1'b0}}, a[WLEN-1:0]}) : a;
    bx   = is_word ? (is_signed ? {{(XLEN-WLEN){b[WLEN-1]}}, b[WLEN-1:0]}
                                : {{(XLEN-WLEN){1'b0}}, b[WLEN-1:0]}) : b;
    sa   = is_signed & ax[XLEN-1];
    sb   = is_signed & bx[XLEN-1];
    ma   = sa ? -ax : ax;
    mb   = sb ? -bx : bx;
    bz   = is_word ? b[WLEN-1:0] == '0 : b == '0;
    q    = neg_q ? -quo : quo;
    r    = neg_r ? -rem : rem;
    sel  = div_q ? q : r;
    res  = word_q ? {{(XLEN-WLEN){sel[WLEN-1]}}, sel[WLEN-1:0]} : sel;
  end
  div_step #(.W(XLEN)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );
  // Word ops place the dividend in the top half of quo so 32 steps leave the quotient in the low half.
  always_ff @(posedge clk) begin
    if (reset | flush) begin
      state <= IDLE;
      cnt   <= '0;
      c     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          div_q  <= get_div;
          word_q <= is_word;
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          rem    <= '0;
          quo    <= is_word ? {ma[WLEN-1:0], {(XLEN-WLEN){1'b0}}} : ma;
          dvs    <= mb;
          if (bz) begin
            c     <= get_div ? '1 : (is_word ? a_wx : a);
            state <= DONE;
          end else begin
            cnt   <= is_word ? DIV_CNT_W'(DIV_ITER_W) : DIV_CNT_W'(DIV_ITER_D);
            state <= CALC;
          end
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt - 1'b1;
          if (cnt == DIV_CNT_W'(1)) state <= FIXUP;
        end
        FIXUP: begin
          c     <= res;
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vector table plus handshake and flush sequences for div_iter.
module tb_div_iter;
  logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic        is_signed = 0, get_div = 0, is_word = 0;
  logic [63:0] a = 0, b = 0;
  logic        in_ready, out_valid;
  logic [63:0] c;
  int          errs = 0, checks = 0;

  typedef struct {
    logic [63:0] a, b;
    logic        sgn, dv, wd;
    logic [63:0] exp;
    int          lat;
  } vec_t;
  vec_t v[14];

  div_iter dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .get_div(get_div), .is_word(is_word),
    .out_valid(out_valid), .out_ready(out_ready), .c(c)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t x, output int n);
    @(negedge clk);
    a = x.a; b = x.b; is_signed = x.sgn; get_div = x.dv; is_word = x.wd; in_valid = 1;
    @(negedge clk);
    in_valid = 0; a = {$urandom, $urandom}; b = {$urandom, $urandom};
    n = 1;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run(input vec_t x, input int idx);
    int n;
    issue(x, n);
    check(out_valid && n == x.lat, $sformatf("latency[%0d]", idx), 64'(n), 64'(x.lat));
    check(c == x.exp, $sformatf("result[%0d]", idx), c, x.exp);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check(!out_valid && in_ready, $sformatf("release[%0d]", idx), {62'b0, out_valid, in_ready}, 64'h1);
  endtask

  initial begin
    int n;
    logic [63:0] held;
    v[0]  = '{64'd100, 64'd7, 0, 1, 0, 64'd14, 66};
    v[1]  = '{64'd100, 64'd7, 0, 0, 0, 64'd2, 66};
    v[2]  = '{64'hFFFFFFFFFFFFFFF9, 64'd2, 1, 1, 0, 64'hFFFFFFFFFFFFFFFD, 66};
    v[3]  = '{64'hFFFFFFFFFFFFFFF9, 64'd2, 1, 0, 0, 64'hFFFFFFFFFFFFFFFF, 66};
    v[4]  = '{64'h1234, 64'd0, 1, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1};
    v[5]  = '{64'h1234, 64'd0, 1, 0, 0, 64'h1234, 1};
    v[6]  = '{64'h80000000, 64'd0, 1, 1, 1, 64'hFFFFFFFFFFFFFFFF, 1};
    v[7]  = '{64'h80000000, 64'hFFFFFFFF00000000, 1, 0, 1, 64'hFFFFFFFF80000000, 1};
    v[8]  = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1, 1, 0, 64'h8000000000000000, 66};
    v[9]  = '{64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0, 64'd0, 66};
    v[10] = '{64'h80000000, 64'hFFFFFFFF, 1, 1, 1, 64'hFFFFFFFF80000000, 34};
    v[11] = '{64'hFFFFFFFF, 64'd2, 0, 1, 1, 64'h000000007FFFFFFF, 34};
    v[12] = '{64'hFFFFFFFF, 64'd2, 0, 0, 1, 64'd1, 34};
    v[13] = '{64'hDEAD000000000064, 64'hBEEF000000000007, 0, 1, 1, 64'd14, 34};
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    check(in_ready, "reset_in_ready", 64'(in_ready), 64'd1);
    check(!out_valid, "reset_out_valid", 64'(out_valid), 64'd0);
    check(c == 0, "reset_c", c, 64'd0);
    for (int i = 0; i < 14; i++) run(v[i], i);
    // DONE holds while out_ready stays low
    issue(v[0], n);
    check(out_valid && c == 64'd14, "hold_first", c, 64'd14);
    held = c;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check(out_valid && !in_ready && c == held, $sformatf("hold[%0d]", i), c, held);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check(!out_valid && in_ready, "hold_release", 64'(out_valid), 64'd0);
    // flush during the 20th CALC cycle
    @(negedge clk);
    a = 64'd100; b = 64'd7; is_signed = 0; get_div = 1; is_word = 0; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    for (int i = 1; i < 20; i++) @(negedge clk);
    check(!in_ready, "busy_before_flush", 64'(in_ready), 64'd0);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check(in_ready && !out_valid && c == 0, "after_flush", {c[61:0], in_ready, out_valid}, 64'h2);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check(n == 0, "no_valid_after_flush", 64'(n), 64'd0);
    // flush wins over a simultaneous request
    in_valid = 1; flush = 1;
    @(negedge clk);
    in_valid = 0; flush = 0;
    check(in_ready && !out_valid, "flush_blocks_accept", 64'(in_ready), 64'd1);
    run(v[0], 99);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
Iterative radix-2 restoring divider for the execute stage. It is the responder side of the multicycle unit's divide request.
- Accepts one RV64M divide/remainder request through a valid/ready handshake.
- Iterates one quotient bit per cycle.
- Holds the result until the multicycle unit consumes it.
- Covers DIV/DIVU/REM/REMU and the W variants, including RISC-V divide-by-zero and overflow semantics.

Parameters:
XLEN, 64, operand/result width
WLEN, 32, word-mode operand width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  synchronous abort; discards any in-flight op
in_valid  in  1  request valid
in_ready  out  1  block can accept (state IDLE)
a  in  XLEN  dividend
b  in  XLEN  divisor
is_signed  in  1  signed operation
get_div  in  1  1 = quotient, 0 = remainder
is_word  in  1  W variant: use a[31:0], b[31:0]
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
c  out  XLEN  result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset/flush values: state=IDLE, in_ready=1, out_valid=0, c=0, counter=0. The flush effect is identical to reset.
- flush has priority over in_valid and over out_ready in the same cycle; no accept happens in a flush cycle.
- States: IDLE, CALC, FIXUP, DONE (div_state_t).
- IDLE: when in_valid & in_ready at cycle T, latch the operands and the flags is_signed, get_div, is_word.
- Operand conditioning: word mode takes a[31:0] and b[31:0], sign-extended if is_signed, else zero-extended.
  - Signed ops convert both operands to magnitudes.
  - Record neg_q = sign(a) ^ sign(b) and neg_r = sign(a).
- Divide-by-zero (b, or b[31:0] in word mode, equals 0): IDLE goes directly to DONE.
  - Quotient = all ones; remainder = a (original, word-sign-extended in word mode).
  - out_valid is asserted at T+1.
- Otherwise: IDLE goes to CALC with counter = 64, or 32 in word mode.
- CALC, one restoring step per cycle:
  - {rem, quo} shifts left by 1.
  - If rem >= divisor magnitude: rem -= divisor and quo[0] = 1.
  - counter decrements by 1; when it reaches 0 the next state is FIXUP.
- FIXUP: negate quo if neg_q, negate rem if neg_r (signed only).
  - Select the result by get_div.
  - Word mode sign-extends from bit 31 regardless of is_signed.
  - Load c; next state is DONE.
- DONE:
  - out_valid=1, c stable.
  - On out_ready the next state is IDLE and out_valid deasserts the next cycle.
  - in_ready stays 0 until IDLE; there is no back-to-back overlap.
- Latency, accept to first out_valid cycle:
  - 64-bit ops: 66 cycles (matches the multicycle DIV_DELAY).
  - Word ops: 34 cycles.
  - Divide-by-zero: 1 cycle.
- Overflow needs no special case; magnitudes are computed unsigned at full width.
  - Signed min / -1 yields quotient = min, remainder 0 (64-bit and word).
- The a and b inputs are ignored outside the accept cycle. The result depends only on latched values.

Decomposition:
- Shared package gets:
  - div_state_t enum {IDLE, CALC, FIXUP, DONE}
  - DIV_CNT_W=7
  - DIV_ITER_D=64, DIV_ITER_W=32
- One combinational sub-module, div_step: a single shift-compare-subtract iteration. Inputs are rem, quo and divisor; outputs are next rem and next quo.
- Sign conditioning and the FSM stay in div_iter.

Test Plan:
1. Unsigned 64-bit: a=100, b=7, DIVU → c=14 with out_valid at accept+66. The same operands with REMU → c=2.
2. Signed 64-bit: a=0xFFFFFFFFFFFFFFF9 (-7), b=2, DIV → 0xFFFFFFFFFFFFFFFD (-3). REM → 0xFFFFFFFFFFFFFFFF (-1).
3. Divide by zero: a=0x1234, b=0. DIV → 0xFFFFFFFFFFFFFFFF and REM → 0x1234, each with out_valid at accept+1. DIVW with a=0x80000000, b=0 → 0xFFFFFFFFFFFFFFFF.
4. Overflow: a=0x8000000000000000, b=-1, DIV → 0x8000000000000000 and REM → 0. DIVW with a=0x80000000, b=0xFFFFFFFF → 0xFFFFFFFF80000000.
5. Word unsigned: a=0xFFFFFFFF, b=2, DIVUW → 0x000000007FFFFFFF at accept+34. REMUW → 1.
6. Handshake and abort:
   - Hold out_ready=0 for 5 cycles in DONE → c and out_valid stable, in_ready=0.
   - Assert flush on the 20th CALC cycle → out_valid never rises and in_ready=1 the next cycle.
   - A following a=100, b=7 DIVU request still returns 14.
